// File: rtl/lcd_timing_gen.sv
// Raster timing generator: registered HSYNC/VSYNC/DE, coordinates and strobes,
// plus a look-ahead pixel request that leads DE by PREFETCH clocks.
//
// state | meaning
// IDLE  | both counter pairs parked at (0,0), outputs idle, waiting for en
// PRIME | one arming clock, then the lead pair advances PREFETCH clocks alone
// RUN   | both pairs advance; en is sampled only on the lead-pair frame wrap
// DRAIN | lead pair frozen, main pair finishes the current frame
module lcd_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 48,
    parameter int   H_BP     = 40,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 13,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 32,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PREFETCH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        line_start,
    output logic        pix_req,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_L   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_S  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_E  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_L   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_S  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_E  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] PREFETCH_L = 12'(PREFETCH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] main_h;
    logic [11:0] main_v;
    logic [11:0] lead_h;
    logic [11:0] lead_v;
    logic [11:0] prime_cnt;

    logic [11:0] main_h_step;
    logic [11:0] main_v_step;
    logic [11:0] lead_h_step;
    logic [11:0] lead_v_step;
    logic        main_wrap;
    logic        lead_wrap;

    logic        lead_live;
    logic        main_live;
    logic        hsync_d;
    logic        vsync_d;
    logic        de_d;
    logic        frame_start_d;
    logic        line_start_d;
    logic        pix_req_d;
    logic        busy_d;

    assign main_wrap = (main_h == H_LAST) && (main_v == V_LAST);
    assign lead_wrap = (lead_h == H_LAST) && (lead_v == V_LAST);

    always_comb begin
        main_h_step = main_h + 12'd1;
        main_v_step = main_v;
        if (main_h == H_LAST) begin
            main_h_step = '0;
            main_v_step = (main_v == V_LAST) ? 12'd0 : main_v + 12'd1;
        end
    end

    always_comb begin
        lead_h_step = lead_h + 12'd1;
        lead_v_step = lead_v;
        if (lead_h == H_LAST) begin
            lead_h_step = '0;
            lead_v_step = (lead_v == V_LAST) ? 12'd0 : lead_v + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = PRIME;
            PRIME:   if (prime_cnt == PREFETCH_L) state_nxt = RUN;
            RUN:     if (lead_wrap && !en) state_nxt = DRAIN;
            DRAIN:   if (main_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first PRIME clock only arms the lead pair; it advances on the next PREFETCH clocks.
    always_comb begin
        lead_live     = (state == RUN) || ((state == PRIME) && (prime_cnt != 12'd0));
        main_live     = (state == RUN) || (state == DRAIN);
        pix_req_d     = lead_live && (lead_h < H_ACT_L) && (lead_v < V_ACT_L);
        de_d          = main_live && (main_h < H_ACT_L) && (main_v < V_ACT_L);
        line_start_d  = main_live && (main_h == 12'd0) && (main_v < V_ACT_L);
        frame_start_d = main_live && (main_h == 12'd0) && (main_v == 12'd0);
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        if (main_live && (main_h >= H_SYNC_S) && (main_h < H_SYNC_E)) begin
            hsync_d = HS_POL;
        end
        if (main_live && (main_v >= V_SYNC_S) && (main_v < V_SYNC_E)) begin
            vsync_d = VS_POL;
        end
        busy_d        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_h    <= '0;
            main_v    <= '0;
            lead_h    <= '0;
            lead_v    <= '0;
            prime_cnt <= '0;
        end else begin
            prime_cnt <= (state == PRIME) ? prime_cnt + 12'd1 : 12'd0;
            if (state == IDLE) begin
                lead_h <= '0;
                lead_v <= '0;
            end else if (lead_live) begin
                lead_h <= lead_h_step;
                lead_v <= lead_v_step;
            end
            if (state == IDLE) begin
                main_h <= '0;
                main_v <= '0;
            end else if (main_live) begin
                main_h <= main_h_step;
                main_v <= main_v_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            pix_req     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            de          <= de_d;
            x           <= main_h;
            y           <= main_v;
            frame_start <= frame_start_d;
            line_start  <= line_start_d;
            pix_req     <= pix_req_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Raster timing generator for the RGB LCD, clocked directly by the PLL output clock (75 MHz from the 27 MHz board oscillator). Produces registered HSYNC/VSYNC/DE, pixel coordinates and frame/line strobes. Also produces a look-ahead pixel request so the upstream frame-buffer read path can hide its latency. Start and stop are frame-aligned, so the panel never sees a truncated frame.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, HSYNC width (clocks)
- H_BP, 40, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, VSYNC width (lines)
- V_BP, 32, vertical back porch (lines)
- HS_POL, 0, HSYNC active level
- VS_POL, 0, VSYNC active level
- PREFETCH, 2, clocks pix_req leads de; legal range 1..H_FP+H_SYNC+H_BP

Ports:
- clk  in  1  pixel clock from the PLL
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; sampled only at frame boundaries
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  data enable, high on active pixels
- x  out  12  horizontal counter, 0..H_TOTAL-1
- y  out  12  vertical counter, 0..V_TOTAL-1
- frame_start  out  1  one-clock pulse with the first de of a frame
- line_start  out  1  one-clock pulse with the first de of each active line
- pix_req  out  1  pixel fetch strobe, exactly PREFETCH clocks before each de-high clock
- busy  out  1  high in any state except IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order: active (h 0..H_ACTIVE-1), FP, SYNC, BP. Frame order: same.
- HSYNC is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. VSYNC is active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Two counter pairs:
  - main (h,v) drives hsync/vsync/de/x/y;
  - lead (lh,lv) drives pix_req.
  - Both wrap h at H_TOTAL-1 to 0 with v+1, and v at V_TOTAL-1 to 0.
- FSM:
  - IDLE: both counter pairs held at (0,0). Outputs idle. If en=1, go to PRIME.
  - PRIME: lead pair advances for PREFETCH clocks; main pair held. After the PREFETCH-th clock, go to RUN.
  - RUN: both pairs advance every clock. Lead leads main by exactly PREFETCH clocks. When the lead pair wraps (V_TOTAL-1, H_TOTAL-1) to (0,0):
    - en=1: stay in RUN;
    - en=0: go to DRAIN.
  - DRAIN: lead pair frozen and pix_req forced to 0. Main pair continues. When main wraps to (0,0), go to IDLE.
- en is ignored in RUN except at the lead wrap. en is ignored in PRIME and DRAIN.
- A frame, once started, always completes. Frames are back-to-back while en stays high.
- rst in any state forces IDLE and counters (0,0) at the next edge. It overrides en.

## Timing
- All outputs are registered and reflect the counter state of the previous clock (1-clock decode latency).
- Reset/IDLE output values:
  - hsync = ~HS_POL, vsync = ~VS_POL;
  - de = 0, x = 0, y = 0;
  - frame_start = 0, line_start = 0, pix_req = 0;
  - busy = 0 (busy is 1 from the clock after en is sampled high in IDLE).
- en sampled high in IDLE at edge k:
  - first pix_req at edge k+2;
  - first de/frame_start at edge k+2+PREFETCH, with x = 0, y = 0.
- pix_req count per frame is exactly H_ACTIVE*V_ACTIVE. Each pix_req precedes its de by exactly PREFETCH clocks, including across line and frame boundaries.
- line_start coincides with de rising (x = 0, y < V_ACTIVE). frame_start coincides with line_start at y = 0.
- vsync changes only on clocks where x = 0.
- Frame period in RUN is exactly H_TOTAL*V_TOTAL clocks, with no gap between frames.

## Test plan
Small parameters for all scenarios: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), PREFETCH = 2, frame = 98 clocks.

- **Reset and start:** rst high, then en = 1. All outputs at idle values during reset. pix_req at k+2; de, frame_start, x = 0, y = 0 at k+4.
- **Free run, 3 frames:** per frame 32 de clocks and 32 pix_req clocks. hsync active at x 10..11. vsync active for the whole of y = 5. frame_start period is 98 clocks.
- **Prefetch alignment:** across 3 frames, each pix_req is followed by de exactly 2 clocks later, including x = 7 to the next line's x = 0.
- **Stop mid-frame:** drop en at y = 2. The current frame completes with all 32 de. No pix_req after the frame. busy falls and idle values hold 1 clock after x = 13, y = 6.
- **Re-enable in DRAIN:** en low at the lead wrap, then high 1 clock later. The block still goes to IDLE. It restarts via PRIME with the first de 4 clocks after IDLE.
- **Reset mid-frame:** rst at x = 5, y = 1 for 1 clock with en = 1. Next edge shows idle outputs. Restart timing matches the reset-and-start scenario.
